// File: rtl/nor_seq_disj_pkg.sv
// Shared definitions for the NOR-sequenced disjunction controller:
// FSM state encodings, micro-program op codes and default widths.
// Optional feature macro: NOR_SEQ_OPSEL_EN (enables the op-select micro-programs).
package nor_seq_disj_pkg;

  localparam int DEF_W     = 4;
  localparam int DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STEP1 = 2'd1,
    STEP2 = 2'd2,
    STEP3 = 2'd3
  } state_t;

  localparam logic [1:0] OP_ORNB = 2'b00;  // a | ~b
  localparam logic [1:0] OP_OR   = 2'b01;  // a | b
  localparam logic [1:0] OP_AND  = 2'b10;  // a & b

  // Reserved code 11 runs the default a|~b program.
  function automatic logic [1:0] eff_op(input logic [1:0] op);
    return (op == 2'b11) ? OP_ORNB : op;
  endfunction

endpackage

// File: rtl/nor_seq_disj_nor_cell.sv
// W-bit bitwise NOR: the single shared datapath cell, one nor gate per bit.
module nor_cell #(
  parameter int W = 4
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] z,
  output logic [W-1:0] y
);

  // One primitive NOR gate per bit, all bits evaluated in parallel.
  for (genvar i = 0; i < W; i++) begin : g_bit
    nor u_nor (y[i], x[i], z[i]);
  end

endmodule

// File: rtl/nor_seq_disj.sv
// Multi-cycle controller computing s = a | ~b through one shared NOR cell.
// Optional feature macro: NOR_SEQ_OPSEL_EN -- when defined, op selects
// a|~b (00/11), a|b (01, two steps) or a&b (10); otherwise op is ignored.
//
// state | meaning
// IDLE  | waiting for start; NOR inputs held at 0
// STEP1 | first NOR micro-step  (r0)
// STEP2 | second NOR micro-step (r1)
// STEP3 | final NOR into s, pulse done, count the operation
module nor_seq_disj
  import nor_seq_disj_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic [1:0]       op,
  output logic             busy,
  output logic             done,
  output logic [W-1:0]     s,
  output logic [CNT_W-1:0] op_cnt
);

  state_t       state;
  logic [W-1:0] a_q, b_q, r0, r1;
  logic [1:0]   op_q;
  logic [W-1:0] nor_x, nor_z, nor_y;

`ifndef NOR_SEQ_OPSEL_EN
  logic unused_op;
  assign unused_op = ^op;
`endif

  nor_cell #(.W(W)) u_nor_cell (
    .x (nor_x),
    .z (nor_z),
    .y (nor_y)
  );

  // Route operands/scratch into the shared NOR cell according to the current micro-step.
  always_comb begin
    nor_x = '0;
    nor_z = '0;
    case (state)
      STEP1: begin
        if (op_q == OP_AND) begin
          nor_x = a_q;
          nor_z = a_q;
        end else begin
          nor_x = b_q;
          nor_z = b_q;
        end
      end
      STEP2: begin
        if (op_q == OP_AND) begin
          nor_x = b_q;
          nor_z = b_q;
        end else if (op_q == OP_OR) begin
          nor_x = a_q;
          nor_z = b_q;
        end else begin
          nor_x = a_q;
          nor_z = r0;
        end
      end
      STEP3: begin
        if (op_q == OP_AND) begin
          nor_x = r0;
          nor_z = r1;
        end else begin
          nor_x = r1;
          nor_z = r1;
        end
      end
      default: begin
        nor_x = '0;
        nor_z = '0;
      end
    endcase
  end

  // Sequencer: latch request, capture one NOR result per step, publish result and count.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      s      <= '0;
      op_cnt <= '0;
      a_q    <= '0;
      b_q    <= '0;
      r0     <= '0;
      r1     <= '0;
      op_q   <= OP_ORNB;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q  <= a;
            b_q  <= b;
            busy <= 1'b1;
`ifdef NOR_SEQ_OPSEL_EN
            op_q  <= eff_op(op);
            // a|b needs no inverted operand, so its first step is skipped.
            state <= (eff_op(op) == OP_OR) ? STEP2 : STEP1;
`else
            op_q  <= OP_ORNB;
            state <= STEP1;
`endif
          end
        end
        STEP1: begin
          r0    <= nor_y;
          state <= STEP2;
        end
        STEP2: begin
          r1    <= nor_y;
          state <= STEP3;
        end
        STEP3: begin
          s      <= nor_y;
          done   <= 1'b1;
          busy   <= 1'b0;
          op_cnt <= op_cnt + 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
